demux_3bit_1to5_reg: RTL and testbench
======================================

# demux_3bit_1to5_reg

Registered 1-to-5 demultiplexer for 3-bit values. It is the distributing counterpart of the 5-to-1 selector. A single valid/ready input stream is steered to one of five output channels, chosen either by an explicit select or by an internal round-robin pointer. Each output channel holds one value in a register until its consumer takes it. The block sits between a single producer and five independent 3-bit consumers.

## Interface
Parameters: none. Width is fixed at 3 and channel count is fixed at 5.

Ports:
- CLK  in  1  system clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- I  in  3  input data
- I_VALID  in  1  producer has data on I
- I_READY  out  1  block can accept I this cycle (combinational)
- S  in  3  explicit channel select; legal values are 0 to 4
- MODE  in  1  0 = route by S; 1 = route by round-robin pointer
- O0, O1, O2, O3, O4  out  3 each  channel data registers
- O_VALID  out  5  bit k set means Ok holds undelivered data
- O_READY  in  5  bit k set means consumer k takes Ok this cycle
- ERR  out  1  sticky flag; set when a transfer is routed by an illegal S value
- ERR_CLR  in  1  synchronous clear for ERR

## Operation
- Target channel T:
  - MODE=0: T = S.
  - MODE=1: T = PTR, a 3-bit pointer in the range 0 to 4.
- Drain of channel k: occurs when O_VALID[k] && O_READY[k]. O_VALID[k] clears next cycle unless channel k is refilled in the same cycle.
- I_READY rules:
  - T legal: I_READY = !O_VALID[T] || O_READY[T]. Simultaneous drain and refill is allowed.
  - MODE=0 with S in 5 to 7: I_READY = 1.
- Accept: occurs when I_VALID && I_READY.
  - T legal: O<T> <= I and O_VALID[T] <= 1.
  - T illegal: the data is discarded, no O_VALID bit changes, and ERR <= 1.
- PTR behaviour:
  - Advances only on an accepted transfer while MODE=1.
  - Sequence is 0,1,2,3,4,0,… (wraps 4 to 0).
  - Holds its value while MODE=0.
  - When MODE switches back to 1, PTR resumes from its held value.
- Data registers Ok change only on an accept into channel k; they hold their value after a drain.
- ERR:
  - ERR_CLR=1 clears ERR next cycle.
  - If a set (illegal-select accept) and ERR_CLR occur in the same cycle, the set wins and ERR = 1.
- Drains of several channels in one cycle are independent. Only one channel can be filled per cycle.

## Timing
- Reset (RSTN=0, asynchronous): O0 to O4 = 3'b000, O_VALID = 5'b00000, ERR = 0, PTR = 0. Outputs hold these values while RSTN is low.
- Reset release: I_READY = 1 in the first cycle after release.
- Latency: data accepted on edge n is visible on O<T> with O_VALID[T]=1 after edge n.
- Throughput:
  - One transfer per cycle when each target channel is empty or draining.
  - In MODE=1 with all consumers always ready, a value is delivered every cycle, cycling through channels 0 to 4.
- Backpressure: when the target is full and not draining, I_READY = 0 and no state changes. The producer must hold I and I_VALID stable until the accept.
- Reset mid-operation: any pending channel data is lost, O_VALID and PTR clear immediately, and no partial transfer survives.
- I_READY depends combinationally on S, MODE, O_VALID and O_READY. There is no combinational path from I_VALID to I_READY.

## Structure
- Shared package `demux_pkg`:
  - DATA_W = 3
  - NUM_CH = 5
  - SEL_MAX = 3'd4
  - Localparams for MODE_SEL = 1'b0 and MODE_RR = 1'b1
- Sub-module `demux_slot`: a one-entry holding register with ports fill, fill_data, drain, data, valid. It applies the same-cycle refill rule and is instantiated five times.
- The top level contains target selection, I_READY generation, PTR and ERR.

## Test plan
- Reset check: hold RSTN=0 and toggle inputs. Expect O_VALID=00000, all Ok=000, ERR=0. After release, expect I_READY=1.
- Explicit routing, MODE=0: S=2, I=3'b101, one cycle with O_READY=0. Expect O2=101 and O_VALID=00100. A second transfer to S=2 sees I_READY=0. Setting O_READY[2]=1 allows it, and O_VALID[2] stays 1 with the new data.
- Round-robin, MODE=1: all O_READY=1, stream I=1..6. Expect channels 0,1,2,3,4,0 to receive 1,2,3,4,5,6, and PTR=1 afterwards.
- Illegal select: MODE=0, S=6, I=3'b111, I_VALID=1. Expect the transfer accepted, O_VALID unchanged, ERR=1 next cycle. Assert ERR_CLR together with another S=6 transfer: ERR stays 1. Assert ERR_CLR alone: ERR=0.
- Backpressure in MODE=1: O_READY=00000, send 5 values. Expect O_VALID=11111 and the 6th value stalls with I_READY=0. Raise O_READY[0]: the 6th value lands in O0 the same cycle channel 0 drains.
- Reset mid-stream: after 3 round-robin transfers, pulse RSTN low between clock edges. Expect O_VALID=00000 immediately. The next transfer in MODE=1 lands in channel 0.

Source files
------------

// File: rtl/demux_3bit_1to5_reg_pkg.sv
// Shared widths, channel count and mode encodings for the registered 1-to-5 demux.
package demux_pkg;
  localparam int DATA_W = 3;
  localparam int NUM_CH = 5;
  localparam logic [2:0] SEL_MAX = 3'd4;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR = 1'b1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [2:0] sel_t;

  // Round-robin successor: 0,1,2,3,4,0,...
  function automatic sel_t next_ptr(input sel_t p);
    return (p >= SEL_MAX) ? 3'd0 : p + 3'd1;
  endfunction
endpackage

// File: rtl/demux_3bit_1to5_reg_if.sv
// Producer stream, five consumer channels, error flag and pointer debug view.
interface demux_3bit_1to5_reg_if;
  import demux_pkg::*;

  // Valid/ready: a beat moves on a rising edge where valid and ready are both 1.
  // The producer holds data and valid until accepted; ready never depends on valid.
  data_t              i;
  logic               i_valid;
  logic               i_ready;
  sel_t               s;
  logic               mode;
  data_t              o0, o1, o2, o3, o4;
  logic [NUM_CH-1:0]  o_valid;
  logic [NUM_CH-1:0]  o_ready;
  logic               err;
  logic               err_clr;
  sel_t               ptr;

  modport master (
    output i, i_valid, s, mode, o_ready, err_clr,
    input  i_ready, o0, o1, o2, o3, o4, o_valid, err, ptr
  );

  modport slave (
    input  i, i_valid, s, mode, o_ready, err_clr,
    output i_ready, o0, o1, o2, o3, o4, o_valid, err, ptr
  );
endinterface

// File: rtl/demux_3bit_1to5_reg_slot.sv
// One-entry holding register; a fill in the same cycle as a drain keeps it full.
module demux_slot
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  fill,
  input  data_t fill_data,
  input  logic  drain,
  output data_t data,
  output logic  valid
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (fill) begin
      data  <= fill_data;
      valid <= 1'b1;
    end else if (drain && valid) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_3bit_1to5_reg.sv
// Registered 1-to-5 demux: target select, ready generation, round-robin pointer, sticky error.
module demux_3bit_1to5_reg
  import demux_pkg::*;
(
  input logic                   clk,
  input logic                   rstn,
  demux_3bit_1to5_reg_if.slave  bus
);

  sel_t              ptr;
  sel_t              tgt;
  logic              tgt_legal;
  logic              tgt_full;
  logic              i_ready;
  logic              accept;
  logic              err;
  logic [NUM_CH-1:0] fill;
  logic [NUM_CH-1:0] valid;
  data_t             slot_data [NUM_CH];

  // An illegal target never blocks: the beat is swallowed and flagged.
  always_comb begin
    tgt       = (bus.mode == MODE_RR) ? ptr : bus.s;
    tgt_legal = (tgt <= SEL_MAX);
    tgt_full  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (tgt == 3'(k)) tgt_full = valid[k] && !bus.o_ready[k];
    end
  end

  assign i_ready = !tgt_full;
  assign accept  = bus.i_valid && i_ready;

  always_comb begin
    fill = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      fill[k] = accept && (tgt == 3'(k));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot u_slot (
      .clk       (clk),
      .rstn      (rstn),
      .fill      (fill[k]),
      .fill_data (bus.i),
      .drain     (bus.o_ready[k]),
      .data      (slot_data[k]),
      .valid     (valid[k])
    );
  end

  // Pointer only moves on accepted round-robin beats, so it resumes where it left off.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (accept && (bus.mode == MODE_RR)) begin
      ptr <= next_ptr(ptr);
    end
  end

  // Setting beats clearing when both happen in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (accept && !tgt_legal) begin
      err <= 1'b1;
    end else if (bus.err_clr) begin
      err <= 1'b0;
    end
  end

  assign bus.i_ready = i_ready;
  assign bus.o_valid = valid;
  assign bus.o0      = slot_data[0];
  assign bus.o1      = slot_data[1];
  assign bus.o2      = slot_data[2];
  assign bus.o3      = slot_data[3];
  assign bus.o4      = slot_data[4];
  assign bus.err     = err;
  assign bus.ptr     = ptr;

endmodule

// File: tb/tb_demux_3bit_1to5_reg.sv
// Directed self-checking bench for demux_3bit_1to5_reg.
module tb_demux_3bit_1to5_reg;
  import demux_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  demux_3bit_1to5_reg_if bus ();

  demux_3bit_1to5_reg dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] o_at(input int k);
    case (k)
      0: return bus.o0;
      1: return bus.o1;
      2: return bus.o2;
      3: return bus.o3;
      default: return bus.o4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i       = 3'd0;
    bus.i_valid = 1'b0;
    bus.s       = 3'd0;
    bus.mode    = MODE_SEL;
    bus.o_ready = 5'b00000;
    bus.err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.i       = 3'($urandom_range(0, 7));
      bus.i_valid = 1'b1;
      bus.s       = 3'($urandom_range(0, 4));
      bus.mode    = 1'($urandom_range(0, 1));
      bus.o_ready = 5'($urandom_range(0, 31));
      tick();
      checks++;
      if (bus.o_valid !== 5'b00000) begin
        errors++; $display("FAIL reset_o_valid got %b exp 00000", bus.o_valid);
      end
      for (int k = 0; k < NUM_CH; k++) begin
        checks++;
        if (o_at(k) !== 3'b000) begin
          errors++; $display("FAIL reset_o%0d got %b exp 000", k, o_at(k));
        end
      end
      checks++;
      if (bus.err !== 1'b0 || bus.ptr !== 3'd0) begin
        errors++; $display("FAIL reset_err_ptr got err=%b ptr=%0d exp err=0 ptr=0", bus.err, bus.ptr);
      end
    end
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_i_ready got %b exp 1", bus.i_ready);
    end
  endtask

  task automatic test_explicit();
    bus.mode = MODE_SEL; bus.s = 3'd2; bus.i = 3'b101; bus.i_valid = 1'b1; bus.o_ready = 5'b00000;
    tick();
    checks++;
    if (bus.o2 !== 3'b101 || bus.o_valid !== 5'b00100) begin
      errors++; $display("FAIL explicit_first got o2=%b ov=%b exp o2=101 ov=00100", bus.o2, bus.o_valid);
    end
    bus.i = 3'b011;
    #1;
    checks++;
    if (bus.i_ready !== 1'b0) begin
      errors++; $display("FAIL explicit_stall_ready got %b exp 0", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.o2 !== 3'b101 || bus.o_valid !== 5'b00100) begin
      errors++; $display("FAIL explicit_stall_hold got o2=%b ov=%b exp o2=101 ov=00100", bus.o2, bus.o_valid);
    end
    bus.o_ready = 5'b00100;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++; $display("FAIL explicit_drain_ready got %b exp 1", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.o2 !== 3'b011 || bus.o_valid !== 5'b00100) begin
      errors++; $display("FAIL explicit_refill got o2=%b ov=%b exp o2=011 ov=00100", bus.o2, bus.o_valid);
    end
    bus.i_valid = 1'b0;
    tick();
    checks++;
    if (bus.o2 !== 3'b011 || bus.o_valid !== 5'b00000) begin
      errors++; $display("FAIL explicit_drain got o2=%b ov=%b exp o2=011 ov=00000", bus.o2, bus.o_valid);
    end
    bus.o_ready = 5'b00000;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_q[$];
    logic [2:0] exp_v;
    int         ch;
    for (int v = 1; v <= 6; v++) exp_q.push_back(3'(v));
    bus.mode = MODE_RR; bus.o_ready = 5'b11111; bus.i_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      ch    = n % 5;
      exp_v = exp_q.pop_front();
      bus.i = exp_v;
      tick();
      checks++;
      if (o_at(ch) !== exp_v || bus.o_valid !== 5'(1 << ch)) begin
        errors++; $display("FAIL rr_beat%0d got o%0d=%b ov=%b exp %b ov=%b",
                           n, ch, o_at(ch), bus.o_valid, exp_v, 5'(1 << ch));
      end
    end
    bus.i_valid = 1'b0;
    tick();
    checks++;
    if (bus.ptr !== 3'd1 || bus.o_valid !== 5'b00000) begin
      errors++; $display("FAIL rr_end got ptr=%0d ov=%b exp ptr=1 ov=00000", bus.ptr, bus.o_valid);
    end
    bus.o_ready = 5'b00000;
  endtask

  task automatic test_illegal();
    bus.mode = MODE_SEL; bus.s = 3'd6; bus.i = 3'b111; bus.i_valid = 1'b1; bus.o_ready = 5'b00000;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_ready got %b exp 1", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.err !== 1'b1 || bus.o_valid !== 5'b00000 || bus.ptr !== 3'd1) begin
      errors++; $display("FAIL illegal_set got err=%b ov=%b ptr=%0d exp err=1 ov=00000 ptr=1",
                         bus.err, bus.o_valid, bus.ptr);
    end
    bus.err_clr = 1'b1;
    tick();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++; $display("FAIL illegal_set_wins got %b exp 1", bus.err);
    end
    bus.i_valid = 1'b0;
    tick();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL illegal_clear got %b exp 0", bus.err);
    end
    bus.err_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mode = MODE_RR; bus.o_ready = 5'b00000; bus.i_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      bus.i = 3'(n + 1);
      tick();
    end
    checks++;
    if (bus.o_valid !== 5'b11111 || bus.o0 !== 3'd1 || bus.o4 !== 3'd5) begin
      errors++; $display("FAIL bp_full got ov=%b o0=%0d o4=%0d exp ov=11111 o0=1 o4=5",
                         bus.o_valid, bus.o0, bus.o4);
    end
    bus.i = 3'd6;
    #1;
    checks++;
    if (bus.i_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall_ready got %b exp 0", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.o0 !== 3'd1 || bus.ptr !== 3'd0) begin
      errors++; $display("FAIL bp_stall_hold got o0=%0d ptr=%0d exp o0=1 ptr=0", bus.o0, bus.ptr);
    end
    bus.o_ready = 5'b00001;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %b exp 1", bus.i_ready);
    end
    tick();
    checks++;
    if (bus.o0 !== 3'd6 || bus.o_valid !== 5'b11111 || bus.ptr !== 3'd1) begin
      errors++; $display("FAIL bp_refill got o0=%0d ov=%b ptr=%0d exp o0=6 ov=11111 ptr=1",
                         bus.o0, bus.o_valid, bus.ptr);
    end
    bus.i_valid = 1'b0; bus.o_ready = 5'b11111;
    tick();
    checks++;
    if (bus.o_valid !== 5'b00000) begin
      errors++; $display("FAIL bp_drain_all got %b exp 00000", bus.o_valid);
    end
    bus.o_ready = 5'b00000;
  endtask

  task automatic test_reset_mid();
    bus.mode = MODE_RR; bus.o_ready = 5'b00000; bus.i_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      bus.i = 3'(n + 2);
      tick();
    end
    checks++;
    if (bus.o_valid !== 5'b01110) begin
      errors++; $display("FAIL mid_pre got %b exp 01110", bus.o_valid);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 5'b00000 || bus.ptr !== 3'd0) begin
      errors++; $display("FAIL mid_async got ov=%b ptr=%0d exp ov=00000 ptr=0", bus.o_valid, bus.ptr);
    end
    @(negedge clk);
    rstn = 1'b1;
    bus.i = 3'd4;
    tick();
    checks++;
    if (bus.o_valid !== 5'b00001 || bus.o0 !== 3'd4) begin
      errors++; $display("FAIL mid_after got ov=%b o0=%0d exp ov=00001 o0=4", bus.o_valid, bus.o0);
    end
    bus.i_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    idle_inputs();
    test_reset();
    test_explicit();
    test_round_robin();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
